// File: rtl/snoop_bus_arbiter.sv
// Snoop bus arbiter for two L1 cache controllers: grants one miss/upgrade at a
// time, broadcasts the snoop to the other L1 and sequences cache-to-cache or memory fill.
module snoop_bus_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int SNOOP_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [3:0]        req_snoop0,
  input  logic [3:0]        req_snoop1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic              is_bus_fetch,
  output logic              is_mem_fetch,
  output logic              snoop_valid0,
  output logic              snoop_valid1,
  output logic [ADDR_W-1:0] snoop_addr,
  output logic [3:0]        bus_snoop,
  input  logic              snoop_ack0,
  input  logic              snoop_ack1,
  input  logic              snoop_hit0,
  input  logic              snoop_hit1,
  input  logic              c2c_done,
  output logic              mem_req,
  input  logic              mem_done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SNOOP = 3'd1,
    C2C   = 3'd2,
    MEM   = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [3:0] CODE_RD   = 4'b0001;
  localparam logic [3:0] CODE_RDX  = 4'b0111;
  localparam logic [3:0] CODE_INV  = 4'b1101;
  localparam logic [7:0] TIMEOUT_C = 8'(SNOOP_TIMEOUT);

  function automatic logic code_legal(input logic [3:0] code);
    return (code == CODE_RD) || (code == CODE_RDX) || (code == CODE_INV);
  endfunction

  state_t              state_r, state_s;
  logic                owner_r, owner_s;
  logic                last_gnt_r, last_gnt_s;
  logic [ADDR_W-1:0]   addr_r, addr_s;
  logic [3:0]          code_r, code_s;
  logic [7:0]          cnt_r, cnt_s, cnt_inc_s;
  logic                gnt0_r, gnt0_s, gnt1_r, gnt1_s;
  logic                done0_r, done0_s, done1_r, done1_s;
  logic                bus_fetch_r, bus_fetch_s, mem_fetch_r, mem_fetch_s;
  logic                sv0_r, sv0_s, sv1_r, sv1_s;
  logic                mem_req_r, mem_req_s;
  logic                ack_s, hit_s;

  // Next-state and next-output computation for the arbitration FSM
  always_comb begin
    state_s     = state_r;
    owner_s     = owner_r;
    last_gnt_s  = last_gnt_r;
    addr_s      = addr_r;
    code_s      = code_r;
    cnt_inc_s   = cnt_r + 8'd1;
    cnt_s       = cnt_r;
    gnt0_s      = gnt0_r;
    gnt1_s      = gnt1_r;
    done0_s     = 1'b0;
    done1_s     = 1'b0;
    bus_fetch_s = 1'b0;
    mem_fetch_s = 1'b0;
    sv0_s       = sv0_r;
    sv1_s       = sv1_r;
    mem_req_s   = mem_req_r;
    ack_s       = 1'b0;
    hit_s       = 1'b0;

    case (state_r)
      IDLE: begin
        if (req0 || req1) begin
          // On a tie the requester that did not win last time gets the bus.
          owner_s = (req0 && req1) ? ~last_gnt_r : req1;
          addr_s  = owner_s ? req_addr1 : req_addr0;
          code_s  = owner_s ? req_snoop1 : req_snoop0;
          gnt0_s  = ~owner_s;
          gnt1_s  = owner_s;
          cnt_s   = 8'd0;
          if (code_legal(code_s)) begin
            state_s = SNOOP;
            sv0_s   = owner_s;
            sv1_s   = ~owner_s;
          end else begin
            state_s = DONE;
            done0_s = ~owner_s;
            done1_s = owner_s;
          end
        end else begin
          state_s = IDLE;
        end
      end

      SNOOP: begin
        ack_s = owner_r ? snoop_ack0 : snoop_ack1;
        hit_s = ack_s & (owner_r ? snoop_hit0 : snoop_hit1);
        if (ack_s || (cnt_inc_s == TIMEOUT_C)) begin
          cnt_s = 8'd0;
          sv0_s = 1'b0;
          sv1_s = 1'b0;
          if (code_r == CODE_INV) begin
            state_s = DONE;
            done0_s = ~owner_r;
            done1_s = owner_r;
          end else if (hit_s) begin
            state_s = C2C;
          end else begin
            state_s   = MEM;
            mem_req_s = 1'b1;
          end
        end else begin
          cnt_s = cnt_inc_s;
        end
      end

      C2C: begin
        if (c2c_done) begin
          state_s     = DONE;
          done0_s     = ~owner_r;
          done1_s     = owner_r;
          bus_fetch_s = 1'b1;
        end else begin
          state_s = C2C;
        end
      end

      MEM: begin
        if (mem_done) begin
          state_s     = DONE;
          mem_req_s   = 1'b0;
          done0_s     = ~owner_r;
          done1_s     = owner_r;
          mem_fetch_s = 1'b1;
        end else begin
          state_s = MEM;
        end
      end

      DONE: begin
        state_s    = IDLE;
        last_gnt_s = owner_r;
        gnt0_s     = 1'b0;
        gnt1_s     = 1'b0;
        code_s     = 4'b0000;
      end

      default: begin
        state_s   = IDLE;
        gnt0_s    = 1'b0;
        gnt1_s    = 1'b0;
        sv0_s     = 1'b0;
        sv1_s     = 1'b0;
        mem_req_s = 1'b0;
        code_s    = 4'b0000;
        cnt_s     = 8'd0;
      end
    endcase
  end

  // State and registered-output update with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      owner_r     <= 1'b0;
      last_gnt_r  <= 1'b1;
      addr_r      <= '0;
      code_r      <= 4'b0000;
      cnt_r       <= 8'd0;
      gnt0_r      <= 1'b0;
      gnt1_r      <= 1'b0;
      done0_r     <= 1'b0;
      done1_r     <= 1'b0;
      bus_fetch_r <= 1'b0;
      mem_fetch_r <= 1'b0;
      sv0_r       <= 1'b0;
      sv1_r       <= 1'b0;
      mem_req_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      owner_r     <= owner_s;
      last_gnt_r  <= last_gnt_s;
      addr_r      <= addr_s;
      code_r      <= code_s;
      cnt_r       <= cnt_s;
      gnt0_r      <= gnt0_s;
      gnt1_r      <= gnt1_s;
      done0_r     <= done0_s;
      done1_r     <= done1_s;
      bus_fetch_r <= bus_fetch_s;
      mem_fetch_r <= mem_fetch_s;
      sv0_r       <= sv0_s;
      sv1_r       <= sv1_s;
      mem_req_r   <= mem_req_s;
    end
  end

  assign gnt0         = gnt0_r;
  assign gnt1         = gnt1_r;
  assign done0        = done0_r;
  assign done1        = done1_r;
  assign is_bus_fetch = bus_fetch_r;
  assign is_mem_fetch = mem_fetch_r;
  assign snoop_valid0 = sv0_r;
  assign snoop_valid1 = sv1_r;
  assign snoop_addr   = addr_r;
  assign bus_snoop    = code_r;
  assign mem_req      = mem_req_r;

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Self-checking bench for snoop_bus_arbiter: per-cycle vectors with expected
// outputs pushed to a scoreboard queue and compared one edge later.
module tb_snoop_bus_arbiter;
  localparam int ADDR_W = 32;
  localparam int TO     = 16;

  logic              clk = 1'b0;
  logic              rst, req0, req1;
  logic [ADDR_W-1:0] req_addr0, req_addr1;
  logic [3:0]        req_snoop0, req_snoop1;
  logic              gnt0, gnt1, done0, done1, is_bus_fetch, is_mem_fetch;
  logic              snoop_valid0, snoop_valid1, mem_req;
  logic [ADDR_W-1:0] snoop_addr;
  logic [3:0]        bus_snoop;
  logic              snoop_ack0, snoop_ack1, snoop_hit0, snoop_hit1, c2c_done, mem_done;

  always #5 clk = ~clk;

  snoop_bus_arbiter #(.ADDR_W(ADDR_W), .SNOOP_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_snoop0(req_snoop0), .req_snoop1(req_snoop1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .is_bus_fetch(is_bus_fetch), .is_mem_fetch(is_mem_fetch),
    .snoop_valid0(snoop_valid0), .snoop_valid1(snoop_valid1),
    .snoop_addr(snoop_addr), .bus_snoop(bus_snoop),
    .snoop_ack0(snoop_ack0), .snoop_ack1(snoop_ack1),
    .snoop_hit0(snoop_hit0), .snoop_hit1(snoop_hit1),
    .c2c_done(c2c_done), .mem_req(mem_req), .mem_done(mem_done)
  );

  // stim: {rst, req0, req1, ack0, ack1, hit0, hit1, c2c_done, mem_done}
  // res : {gnt0, gnt1, done0, done1, bus_fetch, mem_fetch, sv0, sv1, mem_req}
  typedef struct {
    string       name;
    logic [3:0]  c0;
    logic [3:0]  c1;
    logic [8:0]  stim;
    logic [8:0]  res;
    logic [3:0]  bsn;
    logic [31:0] a;
  } vec_t;

  typedef struct {
    string       name;
    logic [12:0] o;
    logic [31:0] a;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mkv(input string n, input logic [3:0] c0, input logic [3:0] c1,
                               input logic [8:0] s, input logic [8:0] r,
                               input logic [3:0] b, input logic [31:0] a);
    vec_t v;
    v.name = n; v.c0 = c0; v.c1 = c1; v.stim = s; v.res = r; v.bsn = b; v.a = a;
    return v;
  endfunction

  task automatic add(input string n, input logic [3:0] c0, input logic [3:0] c1,
                     input logic [8:0] s, input logic [8:0] r,
                     input logic [3:0] b, input logic [31:0] a);
    tbl.push_back(mkv(n, c0, c1, s, r, b, a));
  endtask

  task automatic apply(input vec_t v);
    exp_t        e;
    logic [12:0] got;
    {rst, req0, req1, snoop_ack0, snoop_ack1, snoop_hit0, snoop_hit1, c2c_done, mem_done} = v.stim;
    req_snoop0 = v.c0;
    req_snoop1 = v.c1;
    e.name = v.name; e.o = {v.res, v.bsn}; e.a = v.a;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = {gnt0, gnt1, done0, done1, is_bus_fetch, is_mem_fetch,
           snoop_valid0, snoop_valid1, mem_req, bus_snoop};
    e = sb.pop_front();
    n_vec++;
    if (got !== e.o || snoop_addr !== e.a) begin
      n_bad++;
      $display("FAIL %s @%0t: got outs=%b addr=%h, required outs=%b addr=%h",
               e.name, $time, got, snoop_addr, e.o, e.a);
    end
  endtask

  // Protocol invariants checked every cycle, independent of the vector tables
  always @(negedge clk) begin
    if ((gnt0 && gnt1) || (done0 && !gnt0) || (done1 && !gnt1) ||
        (snoop_valid0 && gnt0) || (snoop_valid1 && gnt1)) begin
      n_bad++;
      $display("FAIL invariant @%0t: gnt=%b%b done=%b%b sv=%b%b, required exclusive grant, done under grant, no snoop to owner",
               $time, gnt0, gnt1, done0, done1, snoop_valid0, snoop_valid1);
    end
  end

  initial begin
    req_addr0 = 32'h0000_1000;
    req_addr1 = 32'h0000_2000;
    {rst, req0, req1, snoop_ack0, snoop_ack1, snoop_hit0, snoop_hit1, c2c_done, mem_done} = 9'b1_00_00_00_0_0;
    req_snoop0 = 4'h1;
    req_snoop1 = 4'h1;

    // reset with req0 held, then memory path (mem_done in cycle 4)
    for (int i = 0; i < 3; i++)
      add("rst_hold", 4'h1, 4'h1, 9'b1_10_00_00_0_0, 9'b00_00_00_00_0, 4'h0, 32'h0);
    add("mem_gnt",  4'h1, 4'h1, 9'b0_10_00_00_0_0, 9'b10_00_00_01_0, 4'h1, 32'h1000);
    add("mem_ack",  4'h1, 4'h1, 9'b0_10_01_00_0_0, 9'b10_00_00_00_1, 4'h1, 32'h1000);
    add("mem_wt_a", 4'h1, 4'h1, 9'b0_10_00_00_1_0, 9'b10_00_00_00_1, 4'h1, 32'h1000);
    add("mem_wt_b", 4'h1, 4'h1, 9'b0_10_00_00_0_0, 9'b10_00_00_00_1, 4'h1, 32'h1000);
    add("mem_done", 4'h1, 4'h1, 9'b0_10_00_00_0_1, 9'b10_10_01_00_0, 4'h1, 32'h1000);
    add("mem_idle", 4'h1, 4'h1, 9'b0_00_00_00_0_0, 9'b00_00_00_00_0, 4'h0, 32'h1000);

    // cache-to-cache path for L1 1, req dropped mid-transaction
    add("c2c_gnt",  4'h1, 4'h7, 9'b0_01_00_00_0_0, 9'b01_00_00_10_0, 4'h7, 32'h2000);
    add("c2c_snp",  4'h1, 4'h7, 9'b0_01_00_00_0_0, 9'b01_00_00_10_0, 4'h7, 32'h2000);
    add("c2c_ack",  4'h1, 4'h7, 9'b0_01_10_10_0_0, 9'b01_00_00_00_0, 4'h7, 32'h2000);
    add("c2c_wt_a", 4'h1, 4'h7, 9'b0_01_00_00_0_1, 9'b01_00_00_00_0, 4'h7, 32'h2000);
    add("c2c_wt_b", 4'h1, 4'h7, 9'b0_00_00_00_0_0, 9'b01_00_00_00_0, 4'h7, 32'h2000);
    add("c2c_done", 4'h1, 4'h7, 9'b0_00_00_00_1_0, 9'b01_01_10_00_0, 4'h7, 32'h2000);
    add("c2c_idle", 4'h1, 4'h7, 9'b0_00_00_00_0_0, 9'b00_00_00_00_0, 4'h0, 32'h2000);

    // tie fairness from reset: grant order 0,1,0,1
    add("tie_rst",  4'h1, 4'h1, 9'b1_11_00_00_0_0, 9'b00_00_00_00_0, 4'h0, 32'h0);
    for (int r = 0; r < 2; r++) begin
      add("tie_gnt0", 4'h1, 4'h1, 9'b0_11_00_00_0_0, 9'b10_00_00_01_0, 4'h1, 32'h1000);
      add("tie_ack1", 4'h1, 4'h1, 9'b0_11_01_00_0_0, 9'b10_00_00_00_1, 4'h1, 32'h1000);
      add("tie_mem0", 4'h1, 4'h1, 9'b0_11_00_00_0_1, 9'b10_10_01_00_0, 4'h1, 32'h1000);
      add("tie_dn0",  4'h1, 4'h1, 9'b0_11_00_00_0_0, 9'b00_00_00_00_0, 4'h0, 32'h1000);
      add("tie_gnt1", 4'h1, 4'h1, 9'b0_11_00_00_0_0, 9'b01_00_00_10_0, 4'h1, 32'h2000);
      add("tie_ack0", 4'h1, 4'h1, 9'b0_11_10_00_0_0, 9'b01_00_00_00_1, 4'h1, 32'h2000);
      add("tie_mem1", 4'h1, 4'h1, 9'b0_11_00_00_0_1, 9'b01_01_01_00_0, 4'h1, 32'h2000);
      add("tie_dn1",  4'h1, 4'h1, 9'b0_11_00_00_0_0, 9'b00_00_00_00_0, 4'h0, 32'h2000);
    end

    foreach (tbl[i]) apply(tbl[i]);

    // invalidate with no ack from L1 1: 16-cycle timeout; the owner's own ack must be ignored
    apply(mkv("inv_gnt", 4'hD, 4'h1, 9'b0_10_00_00_0_0, 9'b10_00_00_01_0, 4'hD, 32'h1000));
    for (int k = 0; k < TO; k++)
      apply(mkv((k == TO - 1) ? "inv_tmo" : "inv_wait", 4'hD, 4'h1, 9'b0_10_10_10_0_0,
                (k == TO - 1) ? 9'b10_10_00_00_0 : 9'b10_00_00_01_0, 4'hD, 32'h1000));
    apply(mkv("inv_idle", 4'hD, 4'h1, 9'b0_00_00_00_0_0, 9'b00_00_00_00_0, 4'h0, 32'h1000));

    // abort in MEM by reset, then illegal code 0011 from L1 1
    apply(mkv("abt_gnt",  4'h1, 4'h3, 9'b0_10_00_00_0_0, 9'b10_00_00_01_0, 4'h1, 32'h1000));
    apply(mkv("abt_ack",  4'h1, 4'h3, 9'b0_10_01_00_0_0, 9'b10_00_00_00_1, 4'h1, 32'h1000));
    apply(mkv("abt_mem",  4'h1, 4'h3, 9'b0_10_00_00_0_0, 9'b10_00_00_00_1, 4'h1, 32'h1000));
    apply(mkv("abt_rst_a", 4'h1, 4'h3, 9'b1_01_00_00_0_1, 9'b00_00_00_00_0, 4'h0, 32'h0));
    apply(mkv("abt_rst_b", 4'h1, 4'h3, 9'b1_01_00_00_0_0, 9'b00_00_00_00_0, 4'h0, 32'h0));
    apply(mkv("ill_done", 4'h1, 4'h3, 9'b0_01_01_01_0_0, 9'b01_01_00_00_0, 4'h3, 32'h2000));
    apply(mkv("ill_idle", 4'h1, 4'h3, 9'b0_00_00_00_0_0, 9'b00_00_00_00_0, 4'h0, 32'h2000));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
